// File: rtl/iobus_pkg.sv
// Shared types and constants for the OTTER IOBUS initiator.
package iobus_pkg;

    localparam logic [31:0] IOBUS_SW_ADDR  = 32'h1100_8000;
    localparam logic [31:0] IOBUS_BTN_ADDR = 32'h1100_8004;
    localparam logic [31:0] IOBUS_LED_ADDR = 32'h1100_C000;
    localparam logic [31:0] IOBUS_SEG_ADDR = 32'h1100_C004;
    localparam logic [31:0] IOBUS_AN_ADDR  = 32'h1100_C008;
    localparam logic [15:0] IOBUS_BASE     = 16'h1100;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } iobus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } iobus_state_t;

    // Word-aligned and inside the I/O window.
    function automatic logic iobus_addr_ok(input logic [31:0] addr);
        return (addr[31:16] == IOBUS_BASE) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/iobus_cmd_fifo.sv
// Synchronous command FIFO; also exposes the entry behind the head so the
// initiator can chain back-to-back ISSUE cycles.
module iobus_cmd_fifo
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        i_push,
    input  iobus_cmd_t                  i_din,
    input  logic                        i_pop,
    output iobus_cmd_t                  o_head,
    output iobus_cmd_t                  o_head_nxt,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    iobus_cmd_t          r_mem [FIFO_DEPTH];
    logic     [AW-1:0]   r_wr_ptr;
    logic     [AW-1:0]   r_rd_ptr;
    logic     [CW-1:0]   r_count;
    logic     [AW-1:0]   w_rd_nxt;
    logic                w_push;
    logic                w_pop;

    assign o_full   = (r_count == CW'(FIFO_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign w_push   = i_push & ~o_full;
    assign w_pop    = i_pop & ~o_empty;
    assign w_rd_nxt = r_rd_ptr + 1'b1;

    assign o_head     = r_mem[r_rd_ptr];
    assign o_head_nxt = r_mem[w_rd_nxt];

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iobus_initiator.sv
// IOBUS initiator: queued read/write commands issued one per ISSUE cycle.
// Optional address filtering is enabled by defining IOBUS_ADDR_CHECK_EN.
module iobus_initiator
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] iobus_addr,
    output logic [31:0] iobus_out,
    output logic        iobus_wr,
    input  logic [31:0] iobus_in,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    iobus_state_t r_state, w_next;
    iobus_cmd_t   w_head, w_head_nxt, w_sel, w_din;
    logic         w_full, w_empty, w_ok;
    logic [CW-1:0] w_count;

    logic         r_cur_wr, r_cur_bad;
    logic [31:0]  r_bus_addr, r_bus_out;
    logic         r_bus_wr;
    logic         r_rsp_valid, r_rsp_err;
    logic [31:0]  r_rsp_data;

    assign w_din = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};

    iobus_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .i_push     (cmd_valid),
        .i_din      (w_din),
        .i_pop      (r_state == ST_ISSUE),
        .o_head     (w_head),
        .o_head_nxt (w_head_nxt),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign cmd_ready  = ~w_full;
    assign busy       = ~w_empty | (r_state != ST_IDLE);
    assign iobus_addr = r_bus_addr;
    assign iobus_out  = r_bus_out;
    assign iobus_wr   = r_bus_wr;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

    // While ISSUE pops the head, the next command to issue is the one behind it.
    assign w_sel = (r_state == ST_ISSUE) ? w_head_nxt : w_head;

`ifdef IOBUS_ADDR_CHECK_EN
    assign w_ok = iobus_addr_ok(w_sel.addr);
`else
    assign w_ok = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_next = ST_ISSUE;
            ST_ISSUE: begin
                if (!r_cur_wr)
                    w_next = ST_RESP;
                else if (w_count > CW'(1))
                    w_next = ST_ISSUE;
                else
                    w_next = ST_IDLE;
            end
            ST_RESP:  if (rsp_ready) w_next = w_empty ? ST_IDLE : ST_ISSUE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Bus outputs are loaded on entry to ISSUE and idle everywhere else.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cur_wr   <= 1'b0;
            r_cur_bad  <= 1'b0;
            r_bus_addr <= '0;
            r_bus_out  <= '0;
            r_bus_wr   <= 1'b0;
        end else if (w_next == ST_ISSUE) begin
            r_cur_wr   <= w_sel.wr;
            r_cur_bad  <= ~w_ok;
            r_bus_addr <= w_ok ? w_sel.addr : 32'h0;
            r_bus_out  <= (w_ok && w_sel.wr) ? w_sel.data : 32'h0;
            r_bus_wr   <= w_ok & w_sel.wr;
        end else begin
            r_bus_addr <= '0;
            r_bus_out  <= '0;
            r_bus_wr   <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == ST_ISSUE && !r_cur_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_cur_bad ? 32'h0 : iobus_in;
            r_rsp_err   <= r_cur_bad;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iobus_initiator.sv
// Directed bench for iobus_initiator with bus/response scoreboards.
module tb_iobus_initiator;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_data, iobus_addr, iobus_out, iobus_in;
    logic        iobus_wr, busy;

    logic [31:0] sw_val = 32'h0;
    logic [31:0] noise  = 32'h1357_9BDF;
    logic [64:0] bus_q[$];
    logic [32:0] rsp_q[$];
    int          checks = 0, errors = 0, bus_cnt = 0;

    iobus_initiator #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .iobus_addr(iobus_addr), .iobus_out(iobus_out), .iobus_wr(iobus_wr),
        .iobus_in(iobus_in), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Responder: switches register, address 0 returns junk, others a tag.
    assign iobus_in = (iobus_addr == 32'h1100_8000) ? sw_val :
                      (iobus_addr == 32'h0)         ? noise  :
                      {16'hBEEF, iobus_addr[15:0]};

    always @(negedge CLK) noise <= noise + 32'h0101_0101;

    function automatic logic [31:0] resp_model(input logic [31:0] a);
        return (a == 32'h1100_8000) ? sw_val : {16'hBEEF, a[15:0]};
    endfunction

    function automatic bit model_ok(input logic [31:0] a);
`ifdef IOBUS_ADDR_CHECK_EN
        return (a[31:16] == 16'h1100) && (a[1:0] == 2'b00);
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (iobus_wr || iobus_addr != 32'h0 || iobus_out != 32'h0) begin
                logic [64:0] e;
                bus_cnt++;
                e = (bus_q.size() != 0) ? bus_q.pop_front() : 65'bx;
                chk("bus_txn", {iobus_wr, iobus_addr, iobus_out}, e);
            end
            if (rsp_valid && rsp_ready) begin
                logic [32:0] r;
                r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 33'bx;
                chk("rsp", {32'h0, rsp_err, rsp_data}, {32'h0, r});
            end
        end
    end

    // One clock; a command on offer at the edge is recorded as accepted.
    task automatic step(output bit acc);
        acc = cmd_valid && cmd_ready;
        @(posedge CLK);
        #1;
        if (acc) begin
            if (model_ok(cmd_addr))
                bus_q.push_back({cmd_wr, cmd_addr, cmd_wr ? cmd_data : 32'h0});
            if (!cmd_wr)
                rsp_q.push_back(model_ok(cmd_addr) ? {1'b0, resp_model(cmd_addr)}
                                                   : {1'b1, 32'h0});
            cmd_valid = 1'b0;
        end
    endtask

    task automatic offer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit acc;
        offer(wr, a, d);
        for (int i = 0; i < 40; i++) begin
            step(acc);
            if (acc) return;
        end
        chk("send_timeout", {64'h0, cmd_ready}, 65'h1);
        cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, {64'h0, cmd_ready}, 65'h1);
        chk({tag, "_rspv"},  {64'h0, rsp_valid}, 65'h0);
        chk({tag, "_rspd"},  {33'h0, rsp_data},  65'h0);
        chk({tag, "_rspe"},  {64'h0, rsp_err},   65'h0);
        chk({tag, "_bus"},   {iobus_wr, iobus_addr, iobus_out}, 65'h0);
        chk({tag, "_busy"},  {64'h0, busy},      65'h0);
    endtask

    initial begin
        bit acc;
        int c0;

        // Reset state
        #12;
        chk_reset_outs("rst");
        #10 RST = 1'b0;
        @(posedge CLK); #1;

        // Single write: one strobe cycle, no response
        send(1'b1, 32'h1100_C000, 32'h0000_A5A5);
        c0 = bus_cnt;
        step(acc);
        chk("wr_strobe", {iobus_wr, iobus_addr, iobus_out}, {1'b1, 32'h1100_C000, 32'h0000_A5A5});
        chk("wr_norsp", {64'h0, rsp_valid}, 65'h0);
        step(acc);
        chk("wr_one_cycle", {64'h0, iobus_wr}, 65'h0);
        cycles(2);
        chk("wr_count", 65'(bus_cnt - c0), 65'd1);
        chk("wr_norsp2", {64'h0, rsp_valid}, 65'h0);

        // Read: response two cycles after acceptance
        sw_val = 32'h0000_1234;
        send(1'b0, 32'h1100_8000, 32'hFFFF_FFFF);
        chk("rd_lat0", {64'h0, rsp_valid}, 65'h0);
        step(acc);
        chk("rd_issue", {iobus_wr, iobus_addr, iobus_out}, {1'b0, 32'h1100_8000, 32'h0});
        chk("rd_lat1", {64'h0, rsp_valid}, 65'h0);
        step(acc);
        chk("rd_lat2", {31'h0, rsp_valid, rsp_err, rsp_data}, {31'h0, 1'b1, 1'b0, 32'h0000_1234});
        cycles(2);

        // Blocked read, FIFO fills, response held stable
        rsp_ready = 1'b0;
        sw_val = 32'h0000_CAFE;
        send(1'b0, 32'h1100_8000, 32'h0);
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'h1100_C000 + 32'(4 * (i % 3)), 32'h100 + 32'(i));
        chk("full_ready", {64'h0, cmd_ready}, 65'h0);
        offer(1'b1, 32'h1100_C008, 32'h0000_0104);
        for (int i = 0; i < 10; i++) begin
            step(acc);
            chk("hold", {iobus_wr, iobus_addr, 31'h0, rsp_valid, rsp_data},
                {1'b0, 32'h0, 31'h0, 1'b1, 32'h0000_CAFE});
        end
        rsp_ready = 1'b1;
        step(acc);
        for (int i = 0; i < 5; i++) begin
            chk("burst_wr", {64'h0, iobus_wr}, 65'h1);
            step(acc);
        end
        chk("burst_end", {64'h0, iobus_wr}, 65'h0);
        cycles(2);
        chk("drain_busy", {64'h0, busy}, 65'h0);

        // Reset during ISSUE of a queued sequence
        send(1'b1, 32'h1100_C000, 32'h0000_0AAA);
        send(1'b1, 32'h1100_C004, 32'h0000_0BBB);
        send(1'b1, 32'h1100_C008, 32'h0000_0CCC);
        chk("pre_rst_issue", {iobus_wr, iobus_addr, iobus_out}, {1'b1, 32'h1100_C004, 32'h0000_0BBB});
        #1 RST = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        bus_q.delete();
        rsp_q.delete();
        @(posedge CLK); @(posedge CLK); #2 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(acc);
            chk("post_rst_idle", {iobus_wr, iobus_addr, 31'h0, busy, rsp_valid},
                {1'b0, 32'h0, 31'h0, 1'b0, 1'b0});
        end

        // Out-of-window read and misaligned write
        c0 = bus_cnt;
        send(1'b0, 32'h2000_0000, 32'h0);
        cycles(4);
        chk("oow_rd_bus", 65'(bus_cnt - c0), model_ok(32'h2000_0000) ? 65'd1 : 65'd0);
        c0 = bus_cnt;
        send(1'b1, 32'h1100_C001, 32'h0000_5555);
        cycles(4);
        chk("misal_wr_bus", 65'(bus_cnt - c0), model_ok(32'h1100_C001) ? 65'd1 : 65'd0);

        cycles(3);
        chk("bus_q_empty", 65'(bus_q.size()), 65'd0);
        chk("rsp_q_empty", 65'(rsp_q.size()), 65'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
